io_wr_fifo: RTL and testbench
=============================

IO_WR_FIFO -- requirements
Module: io_wr_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the FIFO entry count (power of two, 4..64).
REQ-002 The block SHALL have parameter STAT_AD, default 8'hFF, giving the I/O address of the status/control register.
REQ-003 clk50  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ioad  input  8  CPU I/O address.
REQ-006 iowdt  input  16  CPU I/O write data.
REQ-007 iow  input  1  CPU write strobe; each cycle it is high counts as one write.
REQ-008 ior  input  1  CPU read strobe.
REQ-009 iordt  output  16  CPU read data (status word).
REQ-010 out_ad  output  8  address of the head entry, to the display stage.
REQ-011 out_dt  output  16  data of the head entry.
REQ-012 out_valid  output  1  head entry present.
REQ-013 out_ready  input  1  display stage accepts the head entry.
REQ-014 full  output  1  FIFO holds DEPTH entries.
REQ-015 empty  output  1  FIFO holds 0 entries.
REQ-016 ovf  output  1  sticky overflow flag.
REQ-017 count  output  log2(DEPTH)+1  number of stored entries.

Function
REQ-018 A push SHALL be a cycle with iow=1 and ioad!=STAT_AD; entry stored = {ioad, iowdt}.
REQ-019 A pop SHALL be a cycle with out_valid=1 and out_ready=1.
REQ-020 out_ready while out_valid=0 SHALL have no effect.
REQ-021 Storage SHALL be a circular buffer with write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-022 Output SHALL be first-word-fall-through: out_ad/out_dt always show the entry at the read pointer, and out_valid = !empty.
REQ-023 Latency SHALL be one cycle: a push into an empty FIFO at edge N gives out_valid=1 after edge N.
REQ-024 out_ad/out_dt SHALL be held stable while out_valid=1 and no pop occurs.
REQ-025 When full=0, a push SHALL be accepted.
REQ-026 When full=1, a push SHALL be accepted only if a pop happens in the same cycle; count then stays DEPTH.
REQ-027 When full=1 and a push occurs without a pop, the push SHALL be dropped, ovf SHALL be set to 1, and pointers and count SHALL be unchanged.
REQ-028 A simultaneous push and pop with 0<count<DEPTH SHALL advance both pointers and leave count unchanged.
REQ-029 A push into an empty FIFO SHALL NOT be poppable in the same cycle, since out_valid is still 0.
REQ-030 count SHALL be incremented on an accepted push without a pop, decremented on a pop without an accepted push, and held otherwise.
REQ-031 full SHALL be count==DEPTH and empty SHALL be count==0, both derived from count.
REQ-032 A write (iow=1) with ioad==STAT_AD SHALL NOT be enqueued; if iowdt[0]=1 it SHALL clear ovf.
REQ-033 If an overflow and an ovf clear occur in the same cycle, ovf SHALL end up 1 (set wins).
REQ-034 When ior=1 and ioad==STAT_AD at edge N, iordt after edge N SHALL be {ovf, full, empty, 6'b0, count zero-extended to 7 bits}.
REQ-035 In all other cycles iordt SHALL be registered as 16'h0000.
REQ-036 The status read SHALL sample flag values from before edge N.

Reset
REQ-037 While reset=1, pointers SHALL be 0, count=0, empty=1, full=0, ovf=0, out_valid=0, iordt=16'h0000.
REQ-038 While reset=1, the storage contents SHALL NOT be cleared.
REQ-039 Reset asserted mid-operation SHALL discard all entries immediately, asynchronously.
REQ-040 No push, pop or ovf change SHALL occur on the edge at which reset is still high.

Verification
REQ-041 Single write: push ioad=8'h10, iowdt=16'h1234 with out_ready=0 -> next cycle out_valid=1, out_ad=8'h10, out_dt=16'h1234, count=1; after one cycle of out_ready=1 -> empty=1.
REQ-042 Fill and overflow: 17 pushes (data 0..16) with out_ready=0 -> full=1 after 16, 17th dropped, ovf=1; pops then return 0..15 in order, crossing the pointer wrap.
REQ-043 Full with pop: FIFO full, push 16'hAAAA with out_ready=1 in the same cycle -> accepted, count stays 16, ovf stays 0, 16'hAAAA emerges last.
REQ-044 Status: ovf=1, count=5, ior at 8'hFF -> iordt=16'h8005 next cycle; then write 8'hFF/16'h0001 -> ovf=0 and count unchanged at 5.
REQ-045 Reset mid-stream: 7 entries queued, reset pulsed asynchronously between edges -> empty=1, out_valid=0, count=0 immediately; next push is output at out_dt with no stale data.

Source files
------------

// File: rtl/io_wr_fifo.sv
// CPU I/O write FIFO feeding a display stage, first-word-fall-through output,
// with a status/control register (sticky overflow, full/empty, count) at STAT_AD.
module io_wr_fifo #(
   parameter int         DEPTH   = 16,
   parameter logic [7:0] STAT_AD = 8'hFF
) (
   input  logic                       clk50,
   input  logic                       reset,
   input  logic [7:0]                 ioad,
   input  logic [15:0]                iowdt,
   input  logic                       iow,
   input  logic                       ior,
   output logic [15:0]                iordt,
   output logic [7:0]                 out_ad,
   output logic [15:0]                out_dt,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       full,
   output logic                       empty,
   output logic                       ovf,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef struct packed {
      logic [7:0]  ad;
      logic [15:0] dt;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            push, pop, accept, overflow, stat_wr, stat_rd;
   logic [6:0]      count7;
   entry_t          head;

   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign out_valid = !empty;
   assign head      = mem[rd_ptr];
   assign out_ad    = head.ad;
   assign out_dt    = head.dt;

   assign stat_wr  = iow && (ioad == STAT_AD);
   assign stat_rd  = ior && (ioad == STAT_AD);
   assign push     = iow && (ioad != STAT_AD);
   assign pop      = out_valid && out_ready;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign accept   = push && (!full || pop);
   assign overflow = push && full && !pop;
   assign count7   = 7'(count);

   // Storage is deliberately left out of reset; only pointers define contents.
   always_ff @(posedge clk50) begin
      if (!reset && accept) mem[wr_ptr] <= '{ad: ioad, dt: iowdt};
   end

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         iordt  <= 16'h0000;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         if (accept && !pop)      count <= count + CW'(1);
         else if (pop && !accept) count <= count - CW'(1);
         // Set wins over a simultaneous clear.
         if (overflow)                 ovf <= 1'b1;
         else if (stat_wr && iowdt[0]) ovf <= 1'b0;
         iordt <= stat_rd ? {ovf, full, empty, 6'b0, count7} : 16'h0000;
      end
   end
endmodule

// File: tb/tb_io_wr_fifo.sv
// Self-checking bench for io_wr_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_io_wr_fifo;
   localparam int DEPTH = 16;

   logic        clk50 = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  ioad = 8'h00;
   logic [15:0] iowdt = 16'h0000;
   logic        iow = 1'b0, ior = 1'b0, out_ready = 1'b0;
   logic [15:0] iordt, out_dt;
   logic [7:0]  out_ad;
   logic        out_valid, full, empty, ovf;
   logic [4:0]  count;

   int checks = 0, failures = 0;

   logic [23:0] q[$];
   logic        m_ovf = 1'b0;
   logic [15:0] m_iordt = 16'h0000;

   io_wr_fifo #(.DEPTH(DEPTH), .STAT_AD(8'hFF)) dut (
      .clk50(clk50), .reset(reset), .ioad(ioad), .iowdt(iowdt), .iow(iow),
      .ior(ior), .iordt(iordt), .out_ad(out_ad), .out_dt(out_dt),
      .out_valid(out_valid), .out_ready(out_ready), .full(full),
      .empty(empty), .ovf(ovf), .count(count)
   );

   always #5 clk50 = ~clk50;

   // Drive one cycle of inputs, advance the model across the edge, land 1ns after it.
   task automatic cycle(input logic w, input logic [7:0] a, input logic [15:0] d,
                        input logic r, input logic rdy);
      int          n;
      logic        do_push, do_pop;
      logic [6:0]  n7;
      iow = w; ioad = a; iowdt = d; ior = r; out_ready = rdy;
      n       = q.size();
      n7      = 7'(n);
      do_push = w && (a != 8'hFF);
      do_pop  = (n > 0) && rdy;
      @(posedge clk50);
      if (!reset) begin
         m_iordt = (r && a == 8'hFF) ? {m_ovf, n == DEPTH, n == 0, 6'b0, n7} : 16'h0000;
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            if (n < DEPTH || do_pop) q.push_back({a, d});
            else m_ovf = 1'b1;
         end else if (w && a == 8'hFF && d[0]) m_ovf = 1'b0;
      end
      #1;
      iow = 1'b0; ior = 1'b0; out_ready = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk50); #1;
      reset = 1'b0;
      q.delete(); m_ovf = 1'b0; m_iordt = 16'h0000;
   endtask

   task automatic test_reset();
      // pushes presented while reset is high must be ignored
      cycle(1'b1, 8'h01, 16'h1111, 1'b1, 1'b1);
      cycle(1'b1, 8'h02, 16'h2222, 1'b0, 1'b1);
      checks++;
      if ({out_valid, empty, full, ovf, count, iordt} !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0000}) begin
         failures++;
         $display("FAIL reset_state got v=%b e=%b f=%b o=%b c=%0d rd=%h want v=0 e=1 f=0 o=0 c=0 rd=0000",
                  out_valid, empty, full, ovf, count, iordt);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_write();
      cycle(1'b1, 8'h10, 16'h1234, 1'b0, 1'b0);
      checks++;
      if ({out_valid, out_ad, out_dt, count} !== {1'b1, 8'h10, 16'h1234, 5'd1}) begin
         failures++;
         $display("FAIL single_write got v=%b ad=%h dt=%h c=%0d want v=1 ad=10 dt=1234 c=1",
                  out_valid, out_ad, out_dt, count);
      end
      cycle(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
      checks++;
      if ({empty, out_valid, count} !== {1'b1, 1'b0, 5'd0}) begin
         failures++;
         $display("FAIL single_pop got e=%b v=%b c=%0d want e=1 v=0 c=0", empty, out_valid, count);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 17; i++) begin
         cycle(1'b1, 8'(i), 16'(i), 1'b0, 1'b0);
         if (i == 15) begin
            checks++;
            if ({full, ovf, count} !== {1'b1, 1'b0, 5'd16}) begin
               failures++;
               $display("FAIL fill_full got f=%b o=%b c=%0d want f=1 o=0 c=16", full, ovf, count);
            end
         end
      end
      checks++;
      if ({full, ovf, count, out_dt} !== {1'b1, 1'b1, 5'd16, 16'd0}) begin
         failures++;
         $display("FAIL overflow got f=%b o=%b c=%0d head=%h want f=1 o=1 c=16 head=0000",
                  full, ovf, count, out_dt);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({out_valid, out_ad, out_dt} !== {1'b1, 8'(i), 16'(i)}) begin
            failures++;
            $display("FAIL drain_order[%0d] got v=%b ad=%h dt=%h want v=1 ad=%h dt=%h",
                     i, out_valid, out_ad, out_dt, 8'(i), 16'(i));
         end
         cycle(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
      end
      checks++;
      if ({empty, ovf} !== 2'b11) begin
         failures++;
         $display("FAIL drain_empty got e=%b o=%b want e=1 o=1", empty, ovf);
      end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'h40, 16'(i), 1'b0, 1'b0);
      cycle(1'b1, 8'h33, 16'hAAAA, 1'b0, 1'b1);
      checks++;
      if ({count, ovf, full, out_dt} !== {5'd16, 1'b0, 1'b1, 16'd1}) begin
         failures++;
         $display("FAIL full_pop got c=%0d o=%b f=%b head=%h want c=16 o=0 f=1 head=0001",
                  count, ovf, full, out_dt);
      end
      for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
      checks++;
      if ({count, out_ad, out_dt} !== {5'd1, 8'h33, 16'hAAAA}) begin
         failures++;
         $display("FAIL full_pop_last got c=%0d ad=%h dt=%h want c=1 ad=33 dt=aaaa",
                  count, out_ad, out_dt);
      end
   endtask

   task automatic test_status();
      do_reset();
      for (int i = 0; i < 17; i++) cycle(1'b1, 8'h05, 16'(i), 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
      cycle(1'b0, 8'hFF, 16'h0000, 1'b1, 1'b0);
      checks++;
      if (iordt !== 16'h8005) begin
         failures++;
         $display("FAIL status_read got %h want 8005", iordt);
      end
      cycle(1'b1, 8'hFF, 16'h0001, 1'b0, 1'b0);
      checks++;
      if ({ovf, count, iordt} !== {1'b0, 5'd5, 16'h0000}) begin
         failures++;
         $display("FAIL status_clear got o=%b c=%0d rd=%h want o=0 c=5 rd=0000", ovf, count, iordt);
      end
      cycle(1'b0, 8'hFF, 16'h0000, 1'b1, 1'b0);
      checks++;
      if (iordt !== 16'h0005) begin
         failures++;
         $display("FAIL status_reread got %h want 0005", iordt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 7; i++) cycle(1'b1, 8'h70, 16'hC000 + 16'(i), 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({empty, out_valid, count} !== {1'b1, 1'b0, 5'd0}) begin
         failures++;
         $display("FAIL reset_async got e=%b v=%b c=%0d want e=1 v=0 c=0", empty, out_valid, count);
      end
      @(posedge clk50); #1;
      reset = 1'b0;
      q.delete(); m_ovf = 1'b0; m_iordt = 16'h0000;
      cycle(1'b1, 8'h22, 16'h5A5A, 1'b0, 1'b0);
      checks++;
      if ({out_valid, count, out_ad, out_dt} !== {1'b1, 5'd1, 8'h22, 16'h5A5A}) begin
         failures++;
         $display("FAIL reset_fresh got v=%b c=%0d ad=%h dt=%h want v=1 c=1 ad=22 dt=5a5a",
                  out_valid, count, out_ad, out_dt);
      end
   endtask

   task automatic test_random();
      int  bad = 0;
      logic [23:0] hd;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         logic w, r, rdy;
         logic [7:0] a;
         w   = ($urandom_range(0, 99) < 55);
         a   = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
         r   = ($urandom_range(0, 3) == 0);
         rdy = ($urandom_range(0, 99) < ((k / 500) % 2 ? 70 : 35));
         cycle(w, a, 16'($urandom), r, rdy);
         hd = (q.size() > 0) ? q[0] : 24'h0;
         checks++;
         if (count !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
             out_valid !== (q.size() > 0) || ovf !== m_ovf || iordt !== m_iordt ||
             (q.size() > 0 && {out_ad, out_dt} !== hd)) begin
            failures++;
            if (bad < 5)
               $display("FAIL random[%0d] got c=%0d o=%b rd=%h head=%h%h want c=%0d o=%b rd=%h head=%h",
                        k, count, ovf, iordt, out_ad, out_dt, q.size(), m_ovf, m_iordt, hd);
            bad++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_fill_overflow();
      test_full_pop();
      test_status();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
